// File: rtl/gates_mux_checker.sv
// Self-test sequencer for gates_mux: walks the four (s,b) vectors, samples y_in, counts failing vectors.
// Optional first-failure capture (fail_idx/fail_mask) enabled by GATES_MUX_CHK_FAIL_CAPTURE_EN.
module gates_mux_checker #(
  parameter int SETTLE_CYC = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [6:0] y_in,
  output logic       s_out,
  output logic       b_out,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_cnt
`ifdef GATES_MUX_CHK_FAIL_CAPTURE_EN
  ,
  output logic [1:0] fail_idx,
  output logic [6:0] fail_mask
`endif
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [3:0] SETTLE_LD = 4'(SETTLE_CYC);

  state_t     state;
  state_t     state_nxt;
  logic [3:0] settle_cnt;
  logic [1:0] vec_idx;
  logic [6:0] expected;
  logic [6:0] mismatch;
  logic       accept_start;
  logic       sample_now;
  logic       last_sample;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last_sample) state_nxt = DONE;
      DONE:    if (start) state_nxt = RUN;
      default: state_nxt = IDLE;
    endcase
  end

  // The sample edge is the one where the counter, loaded with SETTLE_CYC, has counted down to 1.
  always_comb begin
    accept_start = (state != RUN) && start;
    sample_now   = (state == RUN) && (settle_cnt == 4'd1);
    last_sample  = sample_now && (vec_idx == 2'd3);
  end

  always_comb begin
    expected = {vec_idx[1] & vec_idx[0],
                vec_idx[1] | vec_idx[0],
                ~vec_idx[1],
                ~(vec_idx[1] & vec_idx[0]),
                ~(vec_idx[1] | vec_idx[0]),
                vec_idx[1] ^ vec_idx[0],
                ~(vec_idx[1] ^ vec_idx[0])};
    mismatch = expected ^ y_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vec_idx    <= 2'd0;
      settle_cnt <= 4'd0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err_cnt    <= 3'd0;
    end else if (accept_start) begin
      vec_idx    <= 2'd0;
      settle_cnt <= SETTLE_LD;
      busy       <= 1'b1;
      done       <= 1'b0;
      err_cnt    <= 3'd0;
    end else if (sample_now) begin
      if (|mismatch) err_cnt <= err_cnt + 3'd1;
      if (last_sample) begin
        busy <= 1'b0;
        done <= 1'b1;
      end else begin
        vec_idx    <= vec_idx + 2'd1;
        settle_cnt <= SETTLE_LD;
      end
    end else if (state == RUN) begin
      settle_cnt <= settle_cnt - 4'd1;
    end
  end

`ifdef GATES_MUX_CHK_FAIL_CAPTURE_EN
  // err_cnt still zero on a failing sample means this is the run's first failure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fail_idx  <= 2'd0;
      fail_mask <= 7'd0;
    end else if (accept_start) begin
      fail_idx  <= 2'd0;
      fail_mask <= 7'd0;
    end else if (sample_now && (|mismatch) && (err_cnt == 3'd0)) begin
      fail_idx  <= vec_idx;
      fail_mask <= mismatch;
    end
  end
`endif

  assign s_out = vec_idx[1];
  assign b_out = vec_idx[0];
  assign pass  = done && (err_cnt == 3'd0);

endmodule

// File: tb/tb_gates_mux_checker.sv
// Bench for gates_mux_checker: two instances (SETTLE_CYC=2 and 1) driven from a shared fault table.
// Define GATES_MUX_CHK_FAIL_CAPTURE_EN to also check fail_idx/fail_mask.
module tb_gates_mux_checker;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [6:0] y_in2, y_in1;
  logic       s2, b2, busy2, done2, pass2;
  logic       s1, b1, busy1, done1, pass1;
  logic [2:0] err2, err1;
`ifdef GATES_MUX_CHK_FAIL_CAPTURE_EN
  logic [1:0] fidx2, fidx1;
  logic [6:0] fmask2, fmask1;
`endif

  // Per-vector XOR corruption applied on top of the ideal gate outputs.
  logic [6:0] fault [4];

  int test_count = 0;
  int fail_count = 0;

  gates_mux_checker #(.SETTLE_CYC(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(start), .y_in(y_in2),
    .s_out(s2), .b_out(b2), .busy(busy2), .done(done2), .pass(pass2), .err_cnt(err2)
`ifdef GATES_MUX_CHK_FAIL_CAPTURE_EN
    , .fail_idx(fidx2), .fail_mask(fmask2)
`endif
  );

  gates_mux_checker #(.SETTLE_CYC(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .y_in(y_in1),
    .s_out(s1), .b_out(b1), .busy(busy1), .done(done1), .pass(pass1), .err_cnt(err1)
`ifdef GATES_MUX_CHK_FAIL_CAPTURE_EN
    , .fail_idx(fidx1), .fail_mask(fmask1)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] golden(input int v);
    int s, b;
    s = v / 2;
    b = v % 2;
    return {1'(s & b), 1'(s | b), 1'(1 - s), 1'(1 - (s & b)),
            1'(1 - (s | b)), 1'(s ^ b), 1'(1 - (s ^ b))};
  endfunction

  always_comb y_in2 = golden(int'({s2, b2})) ^ fault[{s2, b2}];
  always_comb y_in1 = golden(int'({s1, b1})) ^ fault[{s1, b1}];

  function automatic int exp_err(input int sampled);
    int n = 0;
    for (int i = 0; i < sampled && i < 4; i++) if (fault[i] != 7'd0) n++;
    return n;
  endfunction

  task automatic checkOutput(input string tag, input int observed, input int expected);
    test_count++;
    assert (observed === expected) else begin
      fail_count++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic checkInstance(input string name, input int sc, input int k,
                               input logic s, input logic b, input logic busy,
                               input logic done, input logic pass, input logic [2:0] err);
    int  active, vec, e;
    active = (k < 4 * sc) ? 1 : 0;
    vec    = active ? k / sc : 3;
    e      = exp_err(k / sc);
    checkOutput($sformatf("%s_k%0d_vec", name, k), int'({s, b}), vec);
    checkOutput($sformatf("%s_k%0d_busy", name, k), int'(busy), active);
    checkOutput($sformatf("%s_k%0d_done", name, k), int'(done), 1 - active);
    checkOutput($sformatf("%s_k%0d_err", name, k), int'(err), e);
    checkOutput($sformatf("%s_k%0d_pass", name, k), int'(pass), (!active && e == 0) ? 1 : 0);
  endtask

`ifdef GATES_MUX_CHK_FAIL_CAPTURE_EN
  task automatic checkFail(input string name, input logic [1:0] idx, input logic [6:0] mask);
    int ei = 0;
    int em = 0;
    for (int i = 3; i >= 0; i--) if (fault[i] != 7'd0) begin ei = i; em = int'(fault[i]); end
    checkOutput({name, "_fail_idx"}, int'(idx), ei);
    checkOutput({name, "_fail_mask"}, int'(mask), em);
  endtask
`endif

  task automatic checkReset();
    checkOutput("rst_vec2", int'({s2, b2, busy2, done2, pass2}), 0);
    checkOutput("rst_err2", int'(err2), 0);
    checkOutput("rst_vec1", int'({s1, b1, busy1, done1, pass1}), 0);
    checkOutput("rst_err1", int'(err1), 0);
`ifdef GATES_MUX_CHK_FAIL_CAPTURE_EN
    checkOutput("rst_fail2", int'({fidx2, fmask2}), 0);
    checkOutput("rst_fail1", int'({fidx1, fmask1}), 0);
`endif
  endtask

  // One run: start edge is k=0, outputs checked 1 time unit after every edge up to k=10.
  task automatic applyStimulus(input int restart_at);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    checkInstance("s2", 2, 0, s2, b2, busy2, done2, pass2, err2);
    checkInstance("s1", 1, 0, s1, b1, busy1, done1, pass1, err1);
    for (int k = 1; k <= 10; k++) begin
      if (k == restart_at) start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      checkInstance("s2", 2, k, s2, b2, busy2, done2, pass2, err2);
      checkInstance("s1", 1, k, s1, b1, busy1, done1, pass1, err1);
    end
`ifdef GATES_MUX_CHK_FAIL_CAPTURE_EN
    checkFail("s2", fidx2, fmask2);
    checkFail("s1", fidx1, fmask1);
`endif
  endtask

  task automatic setFaults(input logic [6:0] f0, input logic [6:0] f1,
                           input logic [6:0] f2, input logic [6:0] f3);
    fault[0] = f0; fault[1] = f1; fault[2] = f2; fault[3] = f3;
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    setFaults(7'd0, 7'd0, 7'd0, 7'd0);
    repeat (2) @(posedge clk);
    #1;
    checkReset();
    rst_n = 1'b1;

    $display("[TB] golden run");
    applyStimulus(-1);

    $display("[TB] yxo stuck at 0");
    setFaults(7'd0, 7'b0000010, 7'b0000010, 7'd0);
    applyStimulus(-1);

    $display("[TB] start reasserted mid-run");
    applyStimulus(3);

    $display("[TB] yn stuck at 1");
    setFaults(7'd0, 7'd0, 7'b0010000, 7'b0010000);
    applyStimulus(-1);

    $display("[TB] reset mid-run");
    setFaults(7'b1000000, 7'b0000010, 7'b0000010, 7'd0);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    checkOutput("mid_vec2", int'({s2, b2}), 2);
    rst_n = 1'b0;
    #1;
    checkReset();
    #1;
    rst_n = 1'b1;
    setFaults(7'd0, 7'd0, 7'd0, 7'd0);
    applyStimulus(-1);

    $display("[TB] random fault tables");
    for (int r = 0; r < 10; r++) begin
      for (int i = 0; i < 4; i++)
        fault[i] = ($urandom_range(0, 1) == 1) ? 7'($urandom_range(1, 127)) : 7'd0;
      applyStimulus(($urandom_range(0, 1) == 1) ? 3 : -1);
    end

    $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
    $finish;
  end

endmodule
